// File: rtl/skew_buffer_pkg.sv
// rtl/skew_buffer_pkg.sv - shared types and sizing helpers for the skew buffer
package skew_buffer_pkg;

   // selects one of the two tile banks
   typedef logic bank_idx_t;

   // width of the step counter, which runs 0..2*dim-2
   function automatic int step_width(input int dim);
      return $clog2(2 * dim);
   endfunction

   // counter value of the last step of a tile
   function automatic int final_step(input int dim);
      return 2 * dim - 2;
   endfunction

endpackage

// File: rtl/skew_bank.sv
// rtl/skew_bank.sv - one DIMxDIM tile store with row write and diagonal read
module skew_bank
   import skew_buffer_pkg::*;
#(
   parameter int BITS = 8,
   parameter int DIM  = 8,
   parameter int TW   = step_width(DIM)
)
(
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DIM)-1:0]     wrow,
   input  logic signed [BITS-1:0]     wdata [DIM-1:0],
   input  logic [TW-1:0]              t,
   output logic signed [BITS-1:0]     rdata [DIM-1:0]
);

   localparam int AW = $clog2(DIM);

   logic signed [BITS-1:0] mem [DIM-1:0][DIM-1:0];
   logic signed [TW:0]     col [DIM-1:0];

   // store one row per write; data needs no reset, the fill mask guards it
   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < DIM; k++) begin
            mem[wrow][k] <= wdata[k];
         end
      end
   end

   // lane r reads column t-r, zero when that column is outside the tile
   always_comb begin
      for (int r = 0; r < DIM; r++) begin
         col[r] = $signed({1'b0, t}) - $signed((TW+1)'(r));
         if (!col[r][TW] && (col[r] < $signed((TW+1)'(DIM)))) begin
            rdata[r] = mem[r][col[r][AW-1:0]];
         end else begin
            rdata[r] = '0;
         end
      end
   end

endmodule

// File: rtl/skew_buffer.sv
// rtl/skew_buffer.sv - double-buffered diagonal operand skew buffer (option: SKEW_BUFFER_ERR_EN)
module skew_buffer
   import skew_buffer_pkg::*;
#(
   parameter int BITS = 8,
   parameter int DIM  = 8
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       WrEn,
   input  logic [$clog2(DIM)-1:0]     Arow,
   input  logic signed [BITS-1:0]     Ain [DIM-1:0],
   output logic                       wr_rdy,
   input  logic                       en,
   output logic signed [BITS-1:0]     Aout [DIM-1:0],
   output logic                       vld,
   output logic                       busy,
   output logic                       tile_done
`ifdef SKEW_BUFFER_ERR_EN
   ,
   output logic                       err
`endif
);

   localparam int             TW      = step_width(DIM);
   localparam logic [TW-1:0]  T_FINAL = TW'(final_step(DIM));

   bank_idx_t               wr_bank, rd_bank;
   logic [1:0]              full, full_nxt;
   logic [DIM-1:0]          row_written [2];
   logic [DIM-1:0]          mask_nxt;
   logic [TW-1:0]           t;
   logic                    wr_fire, fill_done, step, last_step;
   logic signed [BITS-1:0]  rdata0 [DIM-1:0];
   logic signed [BITS-1:0]  rdata1 [DIM-1:0];
   logic signed [BITS-1:0]  rsel   [DIM-1:0];

   assign wr_rdy    = !full[wr_bank];
   assign wr_fire   = WrEn && wr_rdy;
   assign mask_nxt  = row_written[wr_bank] | (DIM'(1) << Arow);
   assign fill_done = wr_fire && (&mask_nxt);
   assign step      = en && full[rd_bank];
   assign last_step = step && (t == T_FINAL);
   assign busy      = (t != '0);

   skew_bank #(.BITS(BITS), .DIM(DIM), .TW(TW)) u_bank0 (
      .clk   (clk),
      .we    (wr_fire && (wr_bank == 1'b0)),
      .wrow  (Arow),
      .wdata (Ain),
      .t     (t),
      .rdata (rdata0)
   );

   skew_bank #(.BITS(BITS), .DIM(DIM), .TW(TW)) u_bank1 (
      .clk   (clk),
      .we    (wr_fire && (wr_bank == 1'b1)),
      .wrow  (Arow),
      .wdata (Ain),
      .t     (t),
      .rdata (rdata1)
   );

   // diagonal read from whichever bank is streaming
   always_comb begin
      for (int k = 0; k < DIM; k++) begin
         rsel[k] = rd_bank ? rdata1[k] : rdata0[k];
      end
   end

   // a fill and a final step never target the same bank, so both may apply
   always_comb begin
      full_nxt = full;
      if (fill_done) full_nxt[wr_bank] = 1'b1;
      if (last_step) full_nxt[rd_bank] = 1'b0;
   end

   // bank pointers, fill masks, full flags and step counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full           <= '0;
         wr_bank        <= 1'b0;
         rd_bank        <= 1'b0;
         row_written[0] <= '0;
         row_written[1] <= '0;
         t              <= '0;
      end else begin
         full <= full_nxt;
         if (fill_done) begin
            row_written[wr_bank] <= '0;
            wr_bank              <= ~wr_bank;
         end else if (wr_fire) begin
            row_written[wr_bank] <= mask_nxt;
         end
         if (last_step) begin
            t       <= '0;
            rd_bank <= ~rd_bank;
         end else if (step) begin
            t <= t + 1'b1;
         end
      end
   end

   // output lanes: load on a step, clear on an empty en cycle, hold when en=0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DIM; k++) Aout[k] <= '0;
         vld       <= 1'b0;
         tile_done <= 1'b0;
      end else begin
         tile_done <= last_step;
         if (en) begin
            vld <= full[rd_bank];
            for (int k = 0; k < DIM; k++) begin
               Aout[k] <= full[rd_bank] ? rsel[k] : '0;
            end
         end
      end
   end

`ifdef SKEW_BUFFER_ERR_EN
   // sticky protocol error: blocked write, row rewrite, or starved mid-tile step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if ((WrEn && !wr_rdy) ||
                   (wr_fire && row_written[wr_bank][Arow]) ||
                   (en && !full[rd_bank] && busy)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule
